lspc_vram_cpu: RTL and testbench

CPU-side VRAM access sequencer for the LSPC. It sits directly downstream of the LSPC register block and consumes its VRAM address, modulo and write-data registers and its write-request flag. It owns the live VRAM address counter, performs CPU writes and read-prefetches inside the CPU access slots granted by the video timing generator, and returns both the write acknowledge and the read latches.

---
 rtl/lspc_vram_cpu.sv | 171 +++++++++++++++++
 tb/tb_lspc_vram_cpu.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lspc_vram_cpu.sv
// lspc_vram_cpu: CPU-side VRAM access sequencer for the LSPC.
// Holds the live VRAM address counter. CPU writes and read-prefetches are
// issued only in the CPU access slots that the video timing grants.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   WR_VRAM_ADDR          active-low strobe; its rising edge loads the counter
//   REG_VRAMADDR/MOD/RW   register-block values: address, modulo, write data
//   nVRAM_WRITE_REQ       active-low pending-write flag
//   SLOT_LOW/SLOT_HIGH    single-cycle CPU grants for the slow/fast bank
//   LOW_DIN/HIGH_DIN      bank read data, valid the cycle after the address
//   VRAM_WRITE_ACK        one-cycle pulse when a write completes
//   LOW_ADDR/HIGH_ADDR    bank addresses; LOW_WE/HIGH_WE write enables
//   WR_DATA               write data; VRAM_LOW_READ/VRAM_HIGH_READ prefetch latches
//   CUR_ADDR              live address counter
module lspc_vram_cpu (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR_VRAM_ADDR,
    input  logic [15:0] REG_VRAMADDR,
    input  logic [15:0] REG_VRAMMOD,
    input  logic [15:0] REG_VRAMRW,
    input  logic        nVRAM_WRITE_REQ,
    input  logic        SLOT_LOW,
    input  logic        SLOT_HIGH,
    input  logic [15:0] LOW_DIN,
    input  logic [15:0] HIGH_DIN,
    output logic        VRAM_WRITE_ACK,
    output logic [14:0] LOW_ADDR,
    output logic [10:0] HIGH_ADDR,
    output logic        LOW_WE,
    output logic        HIGH_WE,
    output logic [15:0] WR_DATA,
    output logic [15:0] VRAM_LOW_READ,
    output logic [15:0] VRAM_HIGH_READ,
    output logic [15:0] CUR_ADDR
);

    localparam int unsigned AW = 16;
    localparam int unsigned OW = 15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PF_WAIT  = 3'd1,
        PF_DATA  = 3'd2,
        WR_WAIT  = 3'd3,
        ACK      = 3'd4,
        ACK_HOLD = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            pf_pend_q, pf_pend_d;
    logic            strobe_q;
    logic            load_hold_q, load_hold_d;
    logic [15:0]     low_rd_q, low_rd_d;
    logic [15:0]     high_rd_q, high_rd_d;

    logic            sel_slot;
    logic            load_edge;
    logic            wr_do;
    logic            load_now;
    logic            unused_mod_msb;

    assign unused_mod_msb = REG_VRAMMOD[15];

    // Slot of the bank selected by the counter MSB; the other bank's slot is ignored.
    // wr_do is the granted write cycle: WR_WAIT while the selected slot is present.
    always_comb begin
        sel_slot  = addr_q[15] ? SLOT_HIGH : SLOT_LOW;
        load_edge = WR_VRAM_ADDR & ~strobe_q;
        wr_do     = (state_q == WR_WAIT) & sel_slot;
        // A load arriving in the write cycle is deferred so the write keeps its address.
        load_now    = (load_edge & ~wr_do) | load_hold_q;
        load_hold_d = load_edge & wr_do;
    end

    // Next-state, counter and prefetch latch logic.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        pf_pend_d = pf_pend_q;
        low_rd_d  = low_rd_q;
        high_rd_d = high_rd_q;

        case (state_q)
            IDLE: begin
                if (pf_pend_q) begin
                    state_d = PF_WAIT;
                end else if (!nVRAM_WRITE_REQ) begin
                    state_d = WR_WAIT;
                end
            end
            PF_WAIT: begin
                // A new address restarts the wait instead of fetching the old one.
                if (!load_now && sel_slot) begin
                    state_d = PF_DATA;
                end
            end
            PF_DATA: begin
                if (addr_q[15]) begin
                    high_rd_d = HIGH_DIN;
                end else begin
                    low_rd_d = LOW_DIN;
                end
                pf_pend_d = 1'b0;
                state_d   = IDLE;
            end
            WR_WAIT: begin
                if (wr_do) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                addr_d    = {addr_q[15], OW'(addr_q[OW-1:0] + REG_VRAMMOD[OW-1:0])};
                pf_pend_d = 1'b1;
                state_d   = ACK_HOLD;
            end
            ACK_HOLD: begin
                // Wait for the request to drop so one request yields one write.
                if (nVRAM_WRITE_REQ) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A load overrides the increment and always leaves a prefetch pending,
        // which also marks data captured in PF_DATA as stale.
        if (load_now) begin
            addr_d    = REG_VRAMADDR;
            pf_pend_d = 1'b1;
        end
    end

    // State and data registers.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            pf_pend_q   <= 1'b0;
            strobe_q    <= 1'b1;
            load_hold_q <= 1'b0;
            low_rd_q    <= '0;
            high_rd_q   <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pf_pend_q   <= pf_pend_d;
            strobe_q    <= WR_VRAM_ADDR;
            load_hold_q <= load_hold_d;
            low_rd_q    <= low_rd_d;
            high_rd_q   <= high_rd_d;
        end
    end

    // Output decodes of state and counter.
    always_comb begin
        VRAM_WRITE_ACK = (state_q == ACK);
        LOW_WE         = wr_do & ~addr_q[15];
        HIGH_WE        = wr_do & addr_q[15];
        LOW_ADDR       = addr_q[14:0];
        HIGH_ADDR      = addr_q[10:0];
        WR_DATA        = REG_VRAMRW;
        VRAM_LOW_READ  = low_rd_q;
        VRAM_HIGH_READ = high_rd_q;
        CUR_ADDR       = addr_q;
    end

endmodule

// File: tb/tb_lspc_vram_cpu.sv
// Self-checking bench for lspc_vram_cpu: table-driven writes, hand sequences
// for reset/prefetch/starvation/mid-wait load, and randomized transactions
// checked against an address/memory reference model.
module tb_lspc_vram_cpu;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        WR_VRAM_ADDR;
    logic [15:0] REG_VRAMADDR, REG_VRAMMOD, REG_VRAMRW;
    logic        nVRAM_WRITE_REQ;
    logic        SLOT_LOW, SLOT_HIGH;
    logic [15:0] LOW_DIN, HIGH_DIN;
    logic        VRAM_WRITE_ACK;
    logic [14:0] LOW_ADDR;
    logic [10:0] HIGH_ADDR;
    logic        LOW_WE, HIGH_WE;
    logic [15:0] WR_DATA, VRAM_LOW_READ, VRAM_HIGH_READ, CUR_ADDR;

    always #5 CLK = ~CLK;

    lspc_vram_cpu dut (
        .CLK(CLK), .RESET(RESET), .WR_VRAM_ADDR(WR_VRAM_ADDR),
        .REG_VRAMADDR(REG_VRAMADDR), .REG_VRAMMOD(REG_VRAMMOD), .REG_VRAMRW(REG_VRAMRW),
        .nVRAM_WRITE_REQ(nVRAM_WRITE_REQ), .SLOT_LOW(SLOT_LOW), .SLOT_HIGH(SLOT_HIGH),
        .LOW_DIN(LOW_DIN), .HIGH_DIN(HIGH_DIN), .VRAM_WRITE_ACK(VRAM_WRITE_ACK),
        .LOW_ADDR(LOW_ADDR), .HIGH_ADDR(HIGH_ADDR), .LOW_WE(LOW_WE), .HIGH_WE(HIGH_WE),
        .WR_DATA(WR_DATA), .VRAM_LOW_READ(VRAM_LOW_READ), .VRAM_HIGH_READ(VRAM_HIGH_READ),
        .CUR_ADDR(CUR_ADDR)
    );

    typedef struct {
        logic [15:0] addr;
        logic [15:0] mod;
        logic [15:0] data;
        logic [15:0] waddr;
        logic [15:0] wnext;
    } vec_t;

    vec_t tbl[6];

    // Environment VRAM (what the DUT actually talks to) and reference contents.
    logic [15:0] lmem[32768];
    logic [15:0] hmem[2048];
    logic [15:0] ref_lo[32768];
    logic [15:0] ref_hi[2048];

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int n_we, n_ack, we_cyc, ack_cyc;
    logic        we_bank;
    logic [15:0] we_addr, we_data;
    logic [14:0] prev_lo_addr = '0;
    logic [10:0] prev_hi_addr = '0;
    logic [15:0] exp_addr, exp_lo_rd, exp_hi_rd;

    function automatic logic [15:0] model_next(input logic [15:0] a, input logic [15:0] m);
        int unsigned off;
        off = (32'(a[14:0]) + 32'(m[14:0])) % 32768;
        return {a[15], off[14:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive slots, supply read data, observe outputs mid-cycle.
    task automatic cycle(input logic sl, input logic sh);
        SLOT_LOW  = sl;
        SLOT_HIGH = sh;
        LOW_DIN   = lmem[prev_lo_addr];
        HIGH_DIN  = hmem[prev_hi_addr];
        #1;
        if (LOW_WE || HIGH_WE) begin
            n_we++;
            we_cyc  = cyc_cnt;
            we_bank = HIGH_WE;
            we_addr = HIGH_WE ? {5'b0, HIGH_ADDR} : {1'b0, LOW_ADDR};
            we_data = WR_DATA;
            if (LOW_WE)  lmem[LOW_ADDR]  = WR_DATA;
            if (HIGH_WE) hmem[HIGH_ADDR] = WR_DATA;
        end
        if (VRAM_WRITE_ACK) begin
            n_ack++;
            ack_cyc = cyc_cnt;
        end
        prev_lo_addr = LOW_ADDR;
        prev_hi_addr = HIGH_ADDR;
        @(negedge CLK);
        cyc_cnt++;
    endtask

    task automatic load_addr(input logic [15:0] a);
        REG_VRAMADDR = a;
        WR_VRAM_ADDR = 1'b0;
        cycle(1'b0, 1'b0);
        WR_VRAM_ADDR = 1'b1;
        cycle(1'b0, 1'b0);
        exp_addr = a;
    endtask

    // Let a pending prefetch of exp_addr complete, then check latches and counter.
    task automatic run_prefetch(input string name);
        logic s, u;
        for (int i = 0; i < 10; i++) begin
            s = (i == 4) ? 1'b1 : ($urandom_range(0, 3) == 0);
            u = 1'($urandom_range(0, 1));
            if (exp_addr[15]) cycle(u, s);
            else              cycle(s, u);
        end
        if (exp_addr[15]) exp_hi_rd = ref_hi[exp_addr[10:0]];
        else              exp_lo_rd = ref_lo[exp_addr[14:0]];
        chk({name, " low_read"},  32'(VRAM_LOW_READ),  32'(exp_lo_rd));
        chk({name, " high_read"}, 32'(VRAM_HIGH_READ), 32'(exp_hi_rd));
        chk({name, " cur_addr"},  32'(CUR_ADDR),       32'(exp_addr));
    endtask

    task automatic do_write(input string name, input logic [15:0] data, input logic [15:0] mod,
                            input logic [15:0] waddr, input logic [15:0] wnext,
                            input int starve, input int hold,
                            input logic mid_load, input logic [15:0] mid_addr);
        logic s, u, hi;
        REG_VRAMMOD     = mod;
        REG_VRAMRW      = data;
        n_we            = 0;
        n_ack           = 0;
        nVRAM_WRITE_REQ = 1'b0;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        if (mid_load) load_addr(mid_addr);
        hi = waddr[15];
        // Only the wrong bank's slot is offered: nothing may happen.
        for (int i = 0; i < starve; i++) cycle(hi, ~hi);
        chk({name, " starved we"},  32'(n_we),  32'd0);
        chk({name, " starved ack"}, 32'(n_ack), 32'd0);
        for (int i = 0; i < 40 && n_ack == 0; i++) begin
            s = (i == 10) ? 1'b1 : ($urandom_range(0, 3) == 0);
            u = 1'($urandom_range(0, 1));
            if (hi) cycle(u, s);
            else    cycle(s, u);
        end
        chk({name, " addr after ack"}, 32'(CUR_ADDR), 32'(wnext));
        chk({name, " ack pulse end"},  32'(VRAM_WRITE_ACK), 32'd0);
        for (int i = 0; i < hold; i++) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        nVRAM_WRITE_REQ = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        chk({name, " we count"},  32'(n_we),  32'd1);
        chk({name, " ack count"}, 32'(n_ack), 32'd1);
        chk({name, " we bank"},   32'(we_bank), 32'(hi));
        chk({name, " we addr"},   32'(we_addr), hi ? 32'(waddr[10:0]) : 32'(waddr[14:0]));
        chk({name, " we data"},   32'(we_data), 32'(data));
        chk({name, " ack latency"}, 32'(ack_cyc), 32'(we_cyc + 1));
        if (hi) ref_hi[waddr[10:0]] = data;
        else    ref_lo[waddr[14:0]] = data;
        exp_addr = wnext;
        run_prefetch({name, " pf"});
    endtask

    initial begin
        logic [15:0] a, m, d;
        tbl[0] = '{16'h7FFF, 16'h0001, 16'hA5A5, 16'h7FFF, 16'h0000};
        tbl[1] = '{16'h87FF, 16'h8001, 16'h5A5A, 16'h87FF, 16'h8800};
        tbl[2] = '{16'h1234, 16'h0010, 16'h1111, 16'h1234, 16'h1244};
        tbl[3] = '{16'hFFFF, 16'h7FFF, 16'h2222, 16'hFFFF, 16'hFFFE};
        tbl[4] = '{16'h0042, 16'h0000, 16'h3333, 16'h0042, 16'h0042};
        tbl[5] = '{16'h8123, 16'h0800, 16'h4444, 16'h8123, 16'h8923};

        for (int i = 0; i < 32768; i++) begin
            lmem[i]   = 16'(i * 7 + 3);
            ref_lo[i] = 16'(i * 7 + 3);
        end
        for (int i = 0; i < 2048; i++) begin
            hmem[i]   = 16'(i * 13 + 256);
            ref_hi[i] = 16'(i * 13 + 256);
        end
        lmem[16'h1234]   = 16'hBEEF;
        ref_lo[16'h1234] = 16'hBEEF;

        RESET = 1'b1; WR_VRAM_ADDR = 1'b1; nVRAM_WRITE_REQ = 1'b1;
        REG_VRAMADDR = '0; REG_VRAMMOD = '0; REG_VRAMRW = '0;
        SLOT_LOW = 1'b0; SLOT_HIGH = 1'b0; LOW_DIN = '0; HIGH_DIN = '0;
        n_we = 0; n_ack = 0; we_cyc = 0; ack_cyc = 0;
        exp_addr = '0; exp_lo_rd = '0; exp_hi_rd = '0;

        // Reset values.
        repeat (3) cycle(1'b0, 1'b0);
        chk("rst ack",  32'(VRAM_WRITE_ACK), 32'd0);
        chk("rst lowe", 32'(LOW_WE),  32'd0);
        chk("rst hiwe", 32'(HIGH_WE), 32'd0);
        chk("rst addr", 32'(CUR_ADDR), 32'd0);
        chk("rst lord", 32'(VRAM_LOW_READ),  32'd0);
        chk("rst hird", 32'(VRAM_HIGH_READ), 32'd0);
        RESET = 1'b0;
        cycle(1'b0, 1'b0);

        // Load then prefetch with exact slot timing.
        load_addr(16'h1234);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        chk("pf slot addr", 32'(prev_lo_addr), 32'h1234);
        chk("pf not early", 32'(VRAM_LOW_READ), 32'(exp_lo_rd));
        cycle(1'b0, 1'b0);
        chk("pf low data",  32'(VRAM_LOW_READ),  32'hBEEF);
        chk("pf high kept", 32'(VRAM_HIGH_READ), 32'(exp_hi_rd));
        exp_lo_rd = 16'hBEEF;

        // Table-driven writes.
        foreach (tbl[i]) begin
            load_addr(tbl[i].addr);
            run_prefetch($sformatf("tbl%0d load", i));
            do_write($sformatf("tbl%0d", i), tbl[i].data, tbl[i].mod,
                     tbl[i].waddr, tbl[i].wnext, 10, 0, 1'b0, 16'h0);
        end

        // Starved slot and held request.
        load_addr(16'h0500);
        run_prefetch("starve load");
        do_write("starve", 16'h6666, 16'h0003, 16'h0500, 16'h0503, 100, 5, 1'b0, 16'h0);

        // Address load while waiting for the write slot.
        load_addr(16'h0200);
        run_prefetch("midload load");
        do_write("midload", 16'h7777, 16'h0004, 16'h0100, 16'h0104, 10, 0, 1'b1, 16'h0100);

        // Reset in the middle of WR_WAIT abandons the write.
        load_addr(16'h0300);
        run_prefetch("rstmid load");
        n_we = 0; n_ack = 0;
        nVRAM_WRITE_REQ = 1'b0;
        repeat (5) cycle(1'b0, 1'b0);
        RESET = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        chk("rstmid ack",  32'(VRAM_WRITE_ACK), 32'd0);
        chk("rstmid we",   32'(n_we),  32'd0);
        chk("rstmid acks", 32'(n_ack), 32'd0);
        chk("rstmid addr", 32'(CUR_ADDR), 32'd0);
        chk("rstmid lord", 32'(VRAM_LOW_READ),  32'd0);
        chk("rstmid hird", 32'(VRAM_HIGH_READ), 32'd0);
        RESET = 1'b0;
        exp_addr = '0; exp_lo_rd = '0; exp_hi_rd = '0;
        do_write("postrst", 16'h9999, 16'h0001, 16'h0000, 16'h0001, 10, 0, 1'b0, 16'h0);

        // Randomized transactions against the reference model.
        for (int it = 0; it < 20; it++) begin
            a = 16'($urandom);
            m = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            d = 16'($urandom);
            load_addr(a);
            run_prefetch($sformatf("rnd%0d load", it));
            do_write($sformatf("rnd%0d", it), d, m, a, model_next(a, m),
                     $urandom_range(0, 15), $urandom_range(0, 3), 1'b0, 16'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
